// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Inter-stage pipeline register with valid/ready handshake,
//            Tnew / exception / delay-slot sideband and two flush classes.
//            Define SKID_PIPE_EN to add a registered-ready skid entry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W   = 128,
    parameter int TNEW_W   = 4,
    parameter int EXC_W    = 5,
    parameter int EXC_NONE = 0,
    parameter int TNEW_AGE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_is_branch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_is_ds,
    input  logic              flush,
    input  logic              flush_force
);

    localparam logic [EXC_W-1:0] c_exc_none = EXC_W'(EXC_NONE);
    localparam bit               c_age      = (TNEW_AGE != 0);

    function automatic logic [TNEW_W-1:0] f_sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [TNEW_W-1:0] r_tnew;
    logic [EXC_W-1:0]  r_exc;
    logic              r_is_ds;
    logic              r_pending_ds;

    logic w_stall;
    logic w_flush;

    assign w_stall = r_valid && !out_ready;
    // A soft flush is dropped while stalled; the issuer keeps it asserted.
    assign w_flush = flush_force || (flush && !w_stall);

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_tnew  = r_tnew;
    assign out_exc   = r_exc;
    assign out_is_ds = r_is_ds;

`ifdef SKID_PIPE_EN

    logic              r_sk_valid;
    logic [DATA_W-1:0] r_sk_data;
    logic [TNEW_W-1:0] r_sk_tnew;
    logic [EXC_W-1:0]  r_sk_exc;
    logic              r_sk_is_ds;

    // Ready depends only on skid occupancy, cutting the out_ready->in_ready path.
    assign in_ready = !r_sk_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tnew       <= '0;
            r_exc        <= c_exc_none;
            r_is_ds      <= 1'b0;
            r_pending_ds <= 1'b0;
            r_sk_valid   <= 1'b0;
            r_sk_data    <= '0;
            r_sk_tnew    <= '0;
            r_sk_exc     <= c_exc_none;
            r_sk_is_ds   <= 1'b0;
        end else if (w_flush) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tnew       <= '0;
            r_exc        <= c_exc_none;
            r_is_ds      <= 1'b0;
            r_pending_ds <= 1'b0;
            r_sk_valid   <= 1'b0;
            r_sk_data    <= '0;
            r_sk_tnew    <= '0;
            r_sk_exc     <= c_exc_none;
            r_sk_is_ds   <= 1'b0;
        end else if (!w_stall) begin
            if (r_sk_valid) begin
                // Promote the older skid entry; no accept happens this cycle.
                r_valid    <= 1'b1;
                r_data     <= r_sk_data;
                r_tnew     <= r_sk_tnew;
                r_exc      <= r_sk_exc;
                r_is_ds    <= r_sk_is_ds;
                r_sk_valid <= 1'b0;
                r_sk_data  <= '0;
                r_sk_tnew  <= '0;
                r_sk_exc   <= c_exc_none;
                r_sk_is_ds <= 1'b0;
            end else if (in_valid) begin
                r_valid      <= 1'b1;
                r_data       <= in_data;
                r_tnew       <= f_sat_dec(in_tnew);
                r_exc        <= in_exc;
                r_is_ds      <= r_pending_ds;
                r_pending_ds <= in_is_branch;
            end else begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tnew  <= '0;
                r_exc   <= c_exc_none;
                r_is_ds <= 1'b0;
            end
        end else begin
            if (c_age) begin
                r_tnew <= f_sat_dec(r_tnew);
            end
            if (!r_sk_valid && in_valid) begin
                r_sk_valid   <= 1'b1;
                r_sk_data    <= in_data;
                r_sk_tnew    <= f_sat_dec(in_tnew);
                r_sk_exc     <= in_exc;
                r_sk_is_ds   <= r_pending_ds;
                r_pending_ds <= in_is_branch;
            end else if (r_sk_valid && c_age) begin
                r_sk_tnew <= f_sat_dec(r_sk_tnew);
            end
        end
    end

`else

    assign in_ready = !r_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tnew       <= '0;
            r_exc        <= c_exc_none;
            r_is_ds      <= 1'b0;
            r_pending_ds <= 1'b0;
        end else if (w_flush) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tnew       <= '0;
            r_exc        <= c_exc_none;
            r_is_ds      <= 1'b0;
            r_pending_ds <= 1'b0;
        end else if (!w_stall) begin
            if (in_valid) begin
                // A branch directly behind a branch is tagged and re-arms pending.
                r_valid      <= 1'b1;
                r_data       <= in_data;
                r_tnew       <= f_sat_dec(in_tnew);
                r_exc        <= in_exc;
                r_is_ds      <= r_pending_ds;
                r_pending_ds <= in_is_branch;
            end else begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tnew  <= '0;
                r_exc   <= c_exc_none;
                r_is_ds <= 1'b0;
            end
        end else if (c_age) begin
            r_tnew <= f_sat_dec(r_tnew);
        end
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed, scoreboard-checked bench for pipe_stage_reg (both
//            Tnew-aging settings; follows SKID_PIPE_EN if defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int TW = 4;
    localparam int EW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tnew;
    logic [EW-1:0] in_exc;
    logic          in_is_branch;
    logic          out_ready;
    logic          flush;
    logic          flush_force;

    logic          o0_in_ready, o0_out_valid, o0_out_is_ds;
    logic [DW-1:0] o0_out_data;
    logic [TW-1:0] o0_out_tnew;
    logic [EW-1:0] o0_out_exc;
    logic          o1_in_ready, o1_out_valid, o1_out_is_ds;
    logic [DW-1:0] o1_out_data;
    logic [TW-1:0] o1_out_tnew;
    logic [EW-1:0] o1_out_exc;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .EXC_W(EW), .EXC_NONE(0), .TNEW_AGE(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o0_in_ready), .in_data(in_data),
        .in_tnew(in_tnew), .in_exc(in_exc), .in_is_branch(in_is_branch),
        .out_valid(o0_out_valid), .out_ready(out_ready), .out_data(o0_out_data),
        .out_tnew(o0_out_tnew), .out_exc(o0_out_exc), .out_is_ds(o0_out_is_ds),
        .flush(flush), .flush_force(flush_force)
    );

    pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .EXC_W(EW), .EXC_NONE(0), .TNEW_AGE(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o1_in_ready), .in_data(in_data),
        .in_tnew(in_tnew), .in_exc(in_exc), .in_is_branch(in_is_branch),
        .out_valid(o1_out_valid), .out_ready(out_ready), .out_data(o1_out_data),
        .out_tnew(o1_out_tnew), .out_exc(o1_out_exc), .out_is_ds(o1_out_is_ds),
        .flush(flush), .flush_force(flush_force)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tnew;
        logic [EW-1:0] exc;
        logic          ds;
    } ent_t;

    ent_t q[$];
    logic m_pend;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] sdec(input logic [TW-1:0] t);
        return (t == 0) ? 4'd0 : t - 4'd1;
    endfunction

    function automatic logic exp_ready(input logic ordy);
`ifdef SKID_PIPE_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ordy;
`endif
    endfunction

    task automatic check_out();
        chk("out_valid", DW'(o0_out_valid), DW'(q.size() > 0));
        chk("age_valid", DW'(o1_out_valid), DW'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", o0_out_data, q[0].data);
            chk("out_tnew", DW'(o0_out_tnew), DW'(q[0].tnew));
            chk("out_exc", DW'(o0_out_exc), DW'(q[0].exc));
            chk("out_is_ds", DW'(o0_out_is_ds), DW'(q[0].ds));
        end else begin
            chk("bubble_data", o0_out_data, '0);
            chk("bubble_exc", DW'(o0_out_exc), '0);
            chk("bubble_ds", DW'(o0_out_is_ds), '0);
        end
    endtask

    // Drive one cycle of stimulus, update the scoreboard, then check outputs.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [TW-1:0] t,
                         input logic [EW-1:0] e, input logic br, input logic ordy,
                         input logic fl, input logic ff);
        logic rdy, stall;
        ent_t ent;
        in_valid = v; in_data = d; in_tnew = t; in_exc = e; in_is_branch = br;
        out_ready = ordy; flush = fl; flush_force = ff;
        #1;
        rdy = exp_ready(ordy);
        chk("in_ready", DW'(o0_in_ready), DW'(rdy));
        stall = (q.size() > 0) && !ordy;
        if (ff || (fl && !stall)) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy) begin
                ent.data = d; ent.tnew = sdec(t); ent.exc = e; ent.ds = m_pend;
                q.push_back(ent);
                m_pend = br;
            end
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset = 1'b0; in_valid = 0; in_data = '0; in_tnew = '0; in_exc = '0;
        in_is_branch = 0; out_ready = 0; flush = 0; flush_force = 0; m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(o0_out_valid), '0);
        chk("rst_data", o0_out_data, '0);
        chk("rst_tnew", DW'(o0_out_tnew), '0);
        chk("rst_exc", DW'(o0_out_exc), '0);
        chk("rst_ds", DW'(o0_out_is_ds), '0);
        chk("rst_in_ready", DW'(o0_in_ready), DW'(1));
        reset = 1'b1;

        // Basic capture and saturating Tnew decrement
        cycle(1, 'hA5, 3, 0, 0, 1, 0, 0);
        cycle(1, 'h5A, 0, 7, 0, 1, 0, 0);

        // Branch, bubble, tagged slot, untagged follower
        cycle(1, 'hB0, 1, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 'hC1, 2, 0, 0, 1, 0, 0);
        cycle(1, 'hC2, 2, 0, 0, 1, 0, 0);

        // Branch directly followed by branch
        cycle(1, 'hD0, 5, 0, 1, 1, 0, 0);
        cycle(1, 'hD1, 5, 0, 1, 1, 0, 0);
        cycle(1, 'hD2, 5, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);

        // Stall with aging, ignored soft flush, then forced flush
        cycle(1, 'hE0, 4, 3, 1, 1, 0, 0);
        chk("age_tnew0", DW'(o1_out_tnew), DW'(3));
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, (i == 2), 0);
            chk("age_tnew", DW'(o1_out_tnew), DW'(3 - i));
            chk("age_data", o1_out_data, DW'('hE0));
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 'hF0, 2, 0, 0, 1, 0, 0);

        // Soft flush colliding with an accept discards it
        cycle(1, 'h11, 2, 4, 0, 1, 1, 0);

        // Async reset mid-stall with a pending delay slot
        cycle(1, 'h22, 2, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        q.delete();
        m_pend = 1'b0;
        chk("async_valid", DW'(o0_out_valid), '0);
        chk("async_data", o0_out_data, '0);
        chk("async_tnew", DW'(o1_out_tnew), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1, 'h33, 2, 0, 0, 1, 0, 0);

        // Full-throughput back-to-back transfers
        for (int i = 0; i < 8; i++) begin
            cycle(1, {$urandom, $urandom, $urandom, $urandom}, TW'($urandom_range(0, 15)),
                  EW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1, 0, 0);
        end

        // Stall with in_valid held, then release
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 'h44, 3, 0, 0, 1, 0, 0);
        cycle(1, 'h55, 3, 0, 0, 0, 0, 0);
        cycle(1, 'h66, 3, 0, 0, 0, 0, 0);
        cycle(1, 'h66, 3, 0, 0, 1, 0, 0);
        cycle(1, 'h66, 3, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);

        // Forced flush with a possibly full skid
        cycle(1, 'h77, 3, 0, 1, 1, 0, 0);
        cycle(1, 'h88, 3, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 'h99, 3, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed-field ID/EX register.
- Carries an opaque payload plus the hazard and exception sideband: Tnew, exception code and delay-slot flag.
- Uses a valid/ready handshake in place of a bare freeze input, with two flush classes (stall-gated and forced).
- Any pipeline boundary (D/E, E/M, M/W) is an instance of this block; hazard unit and CP0 logic consume its sideband.

Parameters:
DATA_W, 128, payload width in bits
TNEW_W, 4, width of Tnew field (unsigned)
EXC_W, 5, exception code width
EXC_NONE, 0, exception code meaning "no exception"
TNEW_AGE, 0, 1 = held entries' Tnew decrements every stalled cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  payload
in_tnew  in  TNEW_W  cycles until result ready, as seen by upstream stage
in_exc  in  EXC_W  exception code from upstream
in_is_branch  in  1  instruction owns a delay slot (branch/jump, not eret)
out_valid  out  1  stage holds an instruction
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload
out_tnew  out  TNEW_W  Tnew for this stage
out_exc  out  EXC_W  exception code
out_is_ds  out  1  instruction sits in a delay slot
flush  in  1  soft flush (eret), honoured only when not stalled
flush_force  in  1  hard flush (interrupt/exception), always honoured

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_tnew=0, out_exc=EXC_NONE, out_is_ds=0, pending_ds=0.
  - Skid entry, when present, is emptied.
- Stall: stall = out_valid && !out_ready.
- Transfers:
  - Accept = in_valid && in_ready.
  - Bubble = !in_valid && in_ready: the stage loads a zero entry (out_valid=0, data 0, tnew 0, exc EXC_NONE, is_ds 0).
  - Latency is 1 cycle from accept to out_valid.
- Capture rules on accept:
  - out_tnew = (in_tnew==0) ? 0 : in_tnew-1, a saturating decrement.
  - out_exc = in_exc; out_data = in_data.
- Delay-slot tracking:
  - Accepting an instruction with in_is_branch=1 sets pending_ds.
  - The next accepted valid instruction is captured with out_is_ds=1 and clears pending_ds.
  - Bubbles do not consume pending_ds.
  - A branch immediately following a branch sets pending_ds again after tagging.
- Hold: during stall every field is held, except out_tnew, which decrements saturating each stalled cycle when TNEW_AGE=1.
- Flush priority (highest first): reset, flush_force, flush && !stall, normal transfer.
  - A flush zeroes all entries exactly as a bubble does and clears pending_ds.
  - A flush in the same cycle as an accept discards the incoming instruction.
  - flush during stall is ignored, not queued; the issuer must hold it until the stall clears.
- in_ready without SKID_EN: !out_valid || out_ready (combinational).
- Simultaneous in_valid with out_valid && out_ready: a new entry replaces the old one, giving full throughput.

Optional Feature:
SKID_PIPE_EN
- Defined:
  - Adds one skid entry; in_ready becomes a register output equal to "skid empty", with no out_ready-to-in_ready path.
  - An accept during stall lands in the skid entry, which is promoted to the main entry on the next cycle where out_ready=1.
  - Order is preserved.
  - Delay-slot tagging happens at accept time.
  - TNEW_AGE aging applies to both entries.
  - Either flush empties both.
- Undefined: single entry, combinational in_ready as above.

Test Plan:
- Reset released, in_valid=1, in_data=0xA5, in_tnew=3, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_tnew=2; with in_tnew=0 -> out_tnew=0.
- Accept branch, then one bubble, then instr X -> X emerges with out_is_ds=1; the following instr Y has out_is_ds=0.
- out_ready=0 for 3 cycles holding tnew=3, TNEW_AGE=1 -> out_tnew 3,2,1,0 and data unchanged; TNEW_AGE=0 -> stays 3.
- flush=1 while stalled -> entry retained; flush_force=1 while stalled -> out_valid=0, out_exc=EXC_NONE next cycle and pending_ds cleared.
- Assert reset mid-stall with pending_ds=1 -> outputs zero immediately without waiting for a clock; first post-reset instruction has out_is_ds=0.
- SKID_PIPE_EN: stall with in_valid held -> exactly one extra accept, then in_ready=0; release -> both instructions emerge in order on consecutive cycles.
